// File: rtl/chip8_pkg.sv
// Shared CHIP-8 constants: timer channel indices, default clocking and the
// timer width used by the CPU for FX07/FX15/FX18.
package chip8_pkg;

  localparam int TIMER_DELAY      = 0;
  localparam int TIMER_SOUND      = 1;
  localparam int CLK_FREQ_DEFAULT = 12_000_000;
  localparam int TICK_HZ_DEFAULT  = 60;
  localparam int TIMER_W          = 8;

  // Integer clock-ratio helper shared by the tick and tone dividers.
  function automatic int clk_ratio(input int num, input int den);
    return num / den;
  endfunction

endpackage

// File: rtl/chip8_timers_tick_divider.sv
// Exact-period pulse generator: one registered pulse every DIV enabled cycles.
// Holding en low parks the count at zero so a restart begins a full period.
module tick_divider #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic pulse
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] p_q, p_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    p_d     = p_q;
    pulse_d = 1'b0;
    if (!en) begin
      p_d = '0;
    end else if (p_q == LAST) begin
      p_d     = '0;
      pulse_d = 1'b1;
    end else begin
      p_d = p_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q     <= '0;
      pulse_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/chip8_timers.sv
// CHIP-8 60 Hz tick generator and countdown-timer bank with CPU load/read port.
// Define CHIP8_TIMERS_BUZZER_EN to drive buzzer as a BUZZ_HZ square wave.
module chip8_timers
  import chip8_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int TICK_HZ    = TICK_HZ_DEFAULT,
  parameter int NUM_TIMERS = 2,
  parameter int WIDTH      = TIMER_W,
  parameter int SOUND_IDX  = TIMER_SOUND,
  parameter int BUZZ_HZ    = 440,
  localparam int SELW      = $clog2(NUM_TIMERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [SELW-1:0]       wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [SELW-1:0]       rd_sel,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  tick,
  output logic [NUM_TIMERS-1:0] active,
  output logic                  buzzer
);

  localparam int DIV  = clk_ratio(CLK_FREQ, TICK_HZ);
  localparam int HALF = clk_ratio(CLK_FREQ, 2 * BUZZ_HZ);

  if (DIV < 2) begin : g_bad_div
    $error("chip8_timers: CLK_FREQ/TICK_HZ must be at least 2");
  end
  if (HALF < 1) begin : g_bad_buzz
    $error("chip8_timers: BUZZ_HZ too high for CLK_FREQ");
  end
  if (NUM_TIMERS < 2 || SOUND_IDX >= NUM_TIMERS) begin : g_bad_chan
    $error("chip8_timers: invalid NUM_TIMERS/SOUND_IDX");
  end

  logic [WIDTH-1:0] timer_q [NUM_TIMERS];
  logic [WIDTH-1:0] timer_d [NUM_TIMERS];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             buzz_q, buzz_d;

  tick_divider #(.DIV(DIV)) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .pulse (tick)
  );

  // Load beats decrement on a channel; a zero timer never decrements.
  always_comb begin
    for (int i = 0; i < NUM_TIMERS; i++) begin
      timer_d[i] = timer_q[i];
      if (wr_en && (wr_sel == SELW'(i))) begin
        timer_d[i] = wr_data;
      end else if (tick && (timer_q[i] != '0)) begin
        timer_d[i] = timer_q[i] - WIDTH'(1);
      end
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      active[i] = |timer_q[i];
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (rd_sel == SELW'(i)) begin
        rd_data_d = timer_q[i];
      end
    end
  end

`ifdef CHIP8_TIMERS_BUZZER_EN
  logic snd_nxt;
  logic tone_pulse;

  // Enable from the next-state value so the first toggle lands HALF cycles
  // after the sound timer becomes visibly nonzero.
  assign snd_nxt = |timer_d[SOUND_IDX];

  tick_divider #(.DIV(HALF)) u_tone_div (
    .clk   (clk),
    .reset (reset),
    .en    (snd_nxt),
    .pulse (tone_pulse)
  );

  always_comb begin
    buzz_d = 1'b0;
    if (active[SOUND_IDX]) begin
      buzz_d = buzz_q ^ tone_pulse;
    end
  end
`else
  always_comb begin
    buzz_d = active[SOUND_IDX];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        timer_q[i] <= '0;
      end
      rd_data_q <= '0;
      buzz_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        timer_q[i] <= timer_d[i];
      end
      rd_data_q <= rd_data_d;
      buzz_q    <= buzz_d;
    end
  end

  assign rd_data = rd_data_q;
  assign buzzer  = buzz_q;

endmodule
